branch_predictor: RTL and testbench

Parametrised branch predictor for the 5-stage MIPS pipeline: a direct-mapped, optionally tagged branch target buffer with per-entry saturating direction counters. It is looked up with the fetch PC in IF and returns a registered prediction in ID. It is trained by the resolved branch outcome from MM/WB. It replaces the 1-bit valid-only BTB with hysteresis and a power-on clear sweep.

---
 rtl/branch_predictor_pkg.sv | 31 +++
 rtl/branch_predictor_sat_cnt.sv | 34 +++
 rtl/branch_predictor.sv | 183 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the branch predictor slice: default geometry,
// FSM state encodings and the counter initial-value/threshold helpers.
// Imported by branch_predictor (top) and sat_cnt.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    // Default table geometry
    localparam int DEF_INDEX_WIDTH = 10;
    localparam int DEF_TAG_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH   = 2;
    localparam int DEF_ADDR_LSB    = 2;

    // Predictor FSM: clear sweep after reset, then normal operation
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpred_state_e;

    // Value written into a freshly allocated entry: weakly taken
    function automatic int cntWeakTaken(input int cntWidth);
        return 1 << (cntWidth - 1);
    endfunction

    // Bit of the counter that decides the predicted direction
    function automatic int cntThresholdBit(input int cntWidth);
        return cntWidth - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Combinational saturating up/down direction counter.
// Ports:
//   cnt      in  CNT_WIDTH  current counter value
//   taken    in  1          resolved direction (1 = count up)
//   cnt_next out CNT_WIDTH  next counter value, clamped at 0 and all-ones
// ---------------------------------------------------------------------------
module sat_cnt
    import branch_predictor_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 taken,
    output logic [CNT_WIDTH-1:0] cnt_next
);

    // Step toward the resolved direction but hold at either end so the
    // counter never wraps from strongly-taken to strongly-not-taken.
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != '1) begin
                cnt_next = cnt + CNT_WIDTH'(1);
            end
        end else begin
            if (cnt != '0) begin
                cnt_next = cnt - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Looked up with the fetch PC, prediction registered into ID;
// trained by the resolved branch from MM/WB. After reset the table is
// cleared by a sweep of one entry per cycle before ready goes high.
//
// Optional feature macro: BPRED_TAG_EN (store and compare tags). When it is
// undefined the tag storage and comparator are absent and hit = valid.
//
// Ports:
//   clk          in   1   clock
//   rst          in   1   synchronous active-high reset
//   lkup_pc      in   32  fetch PC
//   pred_taken   out  1   registered predicted-taken
//   pred_target  out  32  registered predicted target (0 on miss)
//   upd_valid    in   1   resolved-branch update strobe
//   upd_pc       in   32  PC of the resolved branch
//   upd_taken    in   1   actual direction
//   upd_target   in   32  actual target
//   ready        out  1   high once the clear sweep has finished
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int ADDR_LSB    = DEF_ADDR_LSB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lkup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        ready
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(cntWeakTaken(CNT_WIDTH));
    localparam int CNT_MSB = cntThresholdBit(CNT_WIDTH);

    // Table storage, one array per entry field
    logic                 validMem  [ENTRIES];
    logic [CNT_WIDTH-1:0] cntMem    [ENTRIES];
    logic [31:0]          targetMem [ENTRIES];

    bpred_state_e           state_q;
    logic [INDEX_WIDTH-1:0] sweepIdx_q, sweepIdx_d;
    logic                   ready_q;
    logic                   predTaken_q;
    logic [31:0]            predTarget_q;

    logic [INDEX_WIDTH-1:0] lkupIdx, updIdx;
    logic                   lkupHit, updHit;
    logic [CNT_WIDTH-1:0]   updCntNext;

    logic                   wrEn;
    logic [INDEX_WIDTH-1:0] wrIdx;
    logic                   wrValid;
    logic [CNT_WIDTH-1:0]   wrCnt;
    logic [31:0]            wrTarget;

    logic unusedPcBits;

    assign lkupIdx = lkup_pc[ADDR_LSB +: INDEX_WIDTH];
    assign updIdx  = upd_pc[ADDR_LSB +: INDEX_WIDTH];
    assign unusedPcBits = ^{lkup_pc, upd_pc};

`ifdef BPRED_TAG_EN
    logic [TAG_WIDTH-1:0] tagMem [ENTRIES];
    logic [TAG_WIDTH-1:0] lkupTag, updTag;

    // Tagged build: a hit needs a valid entry whose stored tag matches,
    // so aliasing PCs that share an index are told apart.
    assign lkupTag = lkup_pc[ADDR_LSB+INDEX_WIDTH +: TAG_WIDTH];
    assign updTag  = upd_pc[ADDR_LSB+INDEX_WIDTH +: TAG_WIDTH];
    assign lkupHit = validMem[lkupIdx] && (tagMem[lkupIdx] == lkupTag);
    assign updHit  = validMem[updIdx] && (tagMem[updIdx] == updTag);
`else
    localparam int unusedTagWidth = TAG_WIDTH;

    // Untagged build: any valid entry hits, aliasing PCs share it.
    assign lkupHit = validMem[lkupIdx];
    assign updHit  = validMem[updIdx];
`endif

    sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_satCnt (
        .cnt      (cntMem[updIdx]),
        .taken    (upd_taken),
        .cnt_next (updCntNext)
    );

    assign sweepIdx_d = sweepIdx_q + INDEX_WIDTH'(1);

    // Single write port shared by the clear sweep and the training path.
    // During the sweep every cycle clears one entry and updates are simply
    // dropped. In RUN a hit always rewrites the counter (the target only
    // changes on taken), a taken miss allocates a weakly-taken entry, and a
    // not-taken miss leaves the table alone.
    always_comb begin
        wrEn     = 1'b0;
        wrIdx    = updIdx;
        wrValid  = 1'b1;
        wrCnt    = updCntNext;
        wrTarget = upd_target;
        if (rst) begin
            wrEn = 1'b0;
        end else if (state_q == ST_INIT) begin
            wrEn    = 1'b1;
            wrIdx   = sweepIdx_q;
            wrValid = 1'b0;
            wrCnt   = '0;
        end else if (upd_valid) begin
            if (updHit) begin
                wrEn = 1'b1;
                if (!upd_taken) begin
                    wrTarget = targetMem[updIdx];
                end
            end else if (upd_taken) begin
                wrEn  = 1'b1;
                wrCnt = CNT_INIT;
            end
        end
    end

    // Table write. Because the lookup below reads the arrays on the same
    // edge, a lookup and update to one index in the same cycle sees the
    // old contents, and consecutive updates chain through the stored value.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            validMem[wrIdx]  <= wrValid;
            cntMem[wrIdx]    <= wrCnt;
            targetMem[wrIdx] <= wrTarget;
`ifdef BPRED_TAG_EN
            tagMem[wrIdx]    <= updTag;
`endif
        end
    end

    // Control FSM with registered outputs. Reset restarts the sweep from
    // index 0; ready rises on the edge that clears the last entry, and the
    // registered lookup only produces predictions once in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweepIdx_q   <= '0;
            ready_q      <= 1'b0;
            predTaken_q  <= 1'b0;
            predTarget_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweepIdx_q   <= sweepIdx_d;
                    predTaken_q  <= 1'b0;
                    predTarget_q <= '0;
                    if (sweepIdx_q == '1) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    predTaken_q  <= lkupHit && cntMem[lkupIdx][CNT_MSB];
                    predTarget_q <= lkupHit ? targetMem[lkupIdx] : 32'h0;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign pred_taken  = predTaken_q;
    assign pred_target = predTarget_q;
    assign ready       = ready_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Scoreboard bench: every driven cycle pushes the reference model's
// expected registered outputs; a monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int ENTRIES = 1024;
    localparam int CNT_MAX = 3;
    localparam int CNT_WEAK = 2;

    logic        clk;
    logic        rst;
    logic [31:0] lkup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        ready;

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          valid;
        int          tag;
        int          cnt;
        logic [31:0] target;
    } mEntry_t;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        ready;
    } exp_t;

    mEntry_t model [ENTRIES];
    exp_t    expQ  [$];
    int      initLeft = ENTRIES;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .lkup_pc     (lkup_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model helpers: plain arithmetic on the PC
    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> 12) % 256);
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        int i;
        i = idxOf(pc);
`ifdef BPRED_TAG_EN
        return model[i].valid && (model[i].tag == tagOf(pc));
`else
        return model[i].valid;
`endif
    endfunction

    // Drive one cycle and advance the model by that same cycle
    task automatic applyStimulus(input logic r, input logic [31:0] lpc,
                                 input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt);
        exp_t e;
        int   i;
        @(negedge clk);
        rst = r; lkup_pc = lpc; upd_valid = uv;
        upd_pc = upc; upd_taken = ut; upd_target = utgt;
        if (r) begin
            e.taken = 1'b0; e.target = 32'h0; e.ready = 1'b0;
            for (int k = 0; k < ENTRIES; k++) model[k].valid = 1'b0;
            initLeft = ENTRIES;
        end else if (initLeft > 0) begin
            initLeft--;
            e.taken = 1'b0; e.target = 32'h0; e.ready = (initLeft == 0);
        end else begin
            i = idxOf(lpc);
            if (mHit(lpc)) begin
                e.taken  = (model[i].cnt >= CNT_WEAK);
                e.target = model[i].target;
            end else begin
                e.taken  = 1'b0;
                e.target = 32'h0;
            end
            e.ready = 1'b1;
            if (uv) begin
                i = idxOf(upc);
                if (mHit(upc)) begin
                    if (ut) begin
                        model[i].cnt    = (model[i].cnt + 1 > CNT_MAX) ? CNT_MAX : model[i].cnt + 1;
                        model[i].target = utgt;
                    end else begin
                        model[i].cnt = (model[i].cnt - 1 < 0) ? 0 : model[i].cnt - 1;
                    end
                end else if (ut) begin
                    model[i].valid  = 1'b1;
                    model[i].tag    = tagOf(upc);
                    model[i].cnt    = CNT_WEAK;
                    model[i].target = utgt;
                end
            end
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input logic [31:0] lpc, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, lpc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, pc, 1'b1, pc, t, tgt);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    // Monitor: the DUT presents a registered result every cycle, so one
    // expected entry is popped shortly after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ready", {31'h0, ready}, {31'h0, e.ready});
            checkOutput("pred_taken", {31'h0, pred_taken}, {31'h0, e.taken});
            checkOutput("pred_target", pred_target, e.target);
        end
    end

    initial begin
        logic [31:0] pc, lpc, tgt;
        rst = 1'b0; lkup_pc = 32'h0; upd_valid = 1'b0;
        upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;

        $display("[TB] reset and init sweep");
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(32'h40, ENTRIES + 2);

        $display("[TB] training and hysteresis");
        train(32'h100, 1'b1, 32'h200, 1);
        idle(32'h100, 1);
        train(32'h100, 1'b1, 32'h200, 2);
        train(32'h100, 1'b0, 32'h0, 1);
        idle(32'h100, 1);
        train(32'h100, 1'b0, 32'h0, 2);
        idle(32'h100, 1);

        $display("[TB] saturation");
        train(32'h100, 1'b1, 32'h200, 5);
        train(32'h100, 1'b0, 32'h0, 1);
        idle(32'h100, 1);
        train(32'h100, 1'b0, 32'h0, 3);
        idle(32'h100, 1);

        $display("[TB] aliasing");
        train(32'h100, 1'b1, 32'h200, 1);
        idle(32'h1100, 2);
        train(32'h1100, 1'b1, 32'h3300, 1);
        idle(32'h100, 1);
        idle(32'h1100, 1);

        $display("[TB] same-cycle hazard");
        applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h400);
        idle(32'h300, 1);

        $display("[TB] mid-run reset");
        train(32'h100, 1'b1, 32'h200, 2);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h200, 3);
        idle(32'h100, ENTRIES);
        idle(32'h100, 2);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2000; k++) begin
            pc  = (32'($urandom_range(1, 2)) << 12) | (32'($urandom_range(64, 67)) << 2);
            lpc = (32'($urandom_range(1, 2)) << 12) | (32'($urandom_range(64, 67)) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            applyStimulus(1'b0, lpc, ($urandom_range(0, 99) < 70), pc,
                          ($urandom_range(0, 99) < 60), tgt);
        end
        idle(32'h0, 1);

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() == 0) passed++;
        else $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
